// File: rtl/matrix_mult_3x3_stream.sv
// Serial 3x3 signed matrix multiplier (Y = A*B) built around one pipelined MAC, with valid/ready streams.
// Define SATURATE_EN to clamp each result to the signed WIDTH range instead of wrapping.
module matrix_mult_3x3_stream #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy
);

   localparam int PW = 2 * WIDTH;
   localparam int AW = 2 * WIDTH + 2;

   typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

   state_t state, state_next;

   logic signed [WIDTH-1:0] opnd [0:17];
   logic signed [WIDTH-1:0] ybuf [0:8];

   logic [4:0] load_idx;
   logic [4:0] cnt;
   logic [1:0] row, col, kk;
   logic [3:0] out_idx;

   logic [4:0] a_idx, b_idx;
   logic [3:0] e_idx;
   logic signed [PW-1:0] mul_a, mul_b, prod;
   logic signed [AW-1:0] prod_ext, acc, acc_next;
   logic signed [WIDTH-1:0] result;
   logic       p_valid, p_first, p_last;
   logic [3:0] p_idx;

   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      out_data   = '0;
      busy       = 1'b0;
      case (state)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && load_idx == 5'd17) state_next = COMPUTE;
         end
         COMPUTE: begin
            busy = 1'b1;
            if (cnt == 5'd27) state_next = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = ybuf[out_idx];
            out_last  = (out_idx == 4'd8);
            if (out_ready && out_idx == 4'd8) state_next = LOAD;
         end
         default: state_next = LOAD;
      endcase
   end

   // Operand addressing: A is words 0..8, B is words 9..17, both row-major.
   always_comb begin
      a_idx    = 5'(row) * 5'd3 + 5'(kk);
      b_idx    = 5'd9 + 5'(kk) * 5'd3 + 5'(col);
      e_idx    = 4'(row) * 4'd3 + 4'(col);
      mul_a    = {{WIDTH{opnd[a_idx][WIDTH-1]}}, opnd[a_idx]};
      mul_b    = {{WIDTH{opnd[b_idx][WIDTH-1]}}, opnd[b_idx]};
      prod_ext = {{2{prod[PW-1]}}, prod};
      acc_next = p_first ? prod_ext : acc + prod_ext;
   end

`ifdef SATURATE_EN
   localparam logic signed [AW-1:0] SMAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SMIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   always_comb begin
      if (acc_next > SMAX)      result = SMAX[WIDTH-1:0];
      else if (acc_next < SMIN) result = SMIN[WIDTH-1:0];
      else                      result = acc_next[WIDTH-1:0];
   end
`else
   always_comb begin
      result = acc_next[WIDTH-1:0];
   end
`endif

   // The product is registered, so accumulation trails issue by one cycle; cnt==27 only retires the last term.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_idx <= '0;
         cnt      <= '0;
         row      <= '0;
         col      <= '0;
         kk       <= '0;
         out_idx  <= '0;
         prod     <= '0;
         acc      <= '0;
         p_valid  <= 1'b0;
         p_first  <= 1'b0;
         p_last   <= 1'b0;
         p_idx    <= '0;
      end else begin
         if (p_valid) acc <= acc_next;
         case (state)
            LOAD: begin
               if (in_valid) load_idx <= (load_idx == 5'd17) ? 5'd0 : load_idx + 5'd1;
            end
            COMPUTE: begin
               cnt     <= (cnt == 5'd27) ? 5'd0 : cnt + 5'd1;
               p_valid <= (cnt < 5'd27);
               if (cnt < 5'd27) begin
                  prod    <= mul_a * mul_b;
                  p_first <= (kk == 2'd0);
                  p_last  <= (kk == 2'd2);
                  p_idx   <= e_idx;
                  if (kk == 2'd2) begin
                     kk <= 2'd0;
                     if (col == 2'd2) begin
                        col <= 2'd0;
                        row <= (row == 2'd2) ? 2'd0 : row + 2'd1;
                     end else begin
                        col <= col + 2'd1;
                     end
                  end else begin
                     kk <= kk + 2'd1;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) out_idx <= (out_idx == 4'd8) ? 4'd0 : out_idx + 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && state == LOAD && in_valid) opnd[load_idx] <= in_data;
      if (!rst && p_valid && p_last) ybuf[p_idx] <= result;
   end

endmodule

// File: tb/tb_matrix_mult_3x3_stream.sv
// Self-checking bench for matrix_mult_3x3_stream: fixed vector table, randomized matrices against a
// plain-arithmetic reference model, and reset corner cases. Honors SATURATE_EN like the design.
module tb_matrix_mult_3x3_stream;

   localparam int WIDTH = 16;

   typedef logic [8:0][15:0] mat_t;
   typedef struct packed {
      mat_t       a;
      mat_t       b;
      mat_t       y;
      logic [7:0] gap;
      logic [7:0] stall;
      logic       junk;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             busy;

   int tests = 0;
   int failed = 0;
   int cycle = 0;
   int acceptCycle = 0;

   vec_t tbl [5];

   matrix_mult_3x3_stream #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Hard stop so a wedged design can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic mat_t mk(input int e0, input int e1, input int e2, input int e3, input int e4,
                               input int e5, input int e6, input int e7, input int e8);
      mat_t m;
      m[0] = 16'(e0); m[1] = 16'(e1); m[2] = 16'(e2);
      m[3] = 16'(e3); m[4] = 16'(e4); m[5] = 16'(e5);
      m[6] = 16'(e6); m[7] = 16'(e7); m[8] = 16'(e8);
      return m;
   endfunction

   // Reference: textbook triple loop in 64-bit arithmetic, then wrap or clamp to 16 bits.
   function automatic mat_t refMul(input mat_t a, input mat_t b);
      mat_t   m;
      longint s;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            s = 0;
            for (int k = 0; k < 3; k++)
               s += longint'($signed(a[i*3+k])) * longint'($signed(b[k*3+j]));
`ifdef SATURATE_EN
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
`endif
            m[i*3+j] = s[15:0];
         end
      end
      return m;
   endfunction

   // Streams A then B, with optional random idle gaps; records the cycle that accepted operand 17.
   task automatic applyStimulus(input mat_t a, input mat_t b, input int gapMax);
      int g;
      for (int n = 0; n < 18; n++) begin
         g = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
         repeat (g) begin
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = (n < 9) ? a[n] : b[n-9];
         checkVal($sformatf("in_ready op%0d", n), longint'(in_ready), 1);
         @(negedge clk);
      end
      in_valid    = 1'b0;
      acceptCycle = cycle;
   endtask

   task automatic waitResult(input bit junk);
      int n;
      n = 0;
      checkVal("busy in compute", longint'(busy), 1);
      checkVal("in_ready in compute", longint'(in_ready), 0);
      while (!out_valid && n < 200) begin
         if (junk) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
         end
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      if (!out_valid) checkVal("out_valid timeout", 0, 1);
      else            checkVal("out_valid latency", longint'(cycle - acceptCycle), 28);
   endtask

   task automatic checkOutput(input mat_t y, input int stall, input string tag);
      logic [15:0] hd;
      logic        hl;
      bit          steady;
      int          n;
      in_valid = 1'b0;
      for (int w = 0; w < 9; w++) begin
         n = 0;
         while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!out_valid) begin
            checkVal($sformatf("%s Y%0d timeout", tag, w), 0, 1);
            break;
         end
         hd     = out_data;
         hl     = out_last;
         steady = 1'b1;
         out_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (out_data !== hd || out_last !== hl || out_valid !== 1'b1) steady = 1'b0;
         end
         if (stall > 0) checkVal($sformatf("%s Y%0d hold", tag, w), longint'(steady), 1);
         checkVal($sformatf("%s Y%0d data", tag, w), longint'($signed(out_data)), longint'($signed(y[w])));
         checkVal($sformatf("%s Y%0d last", tag, w), longint'(out_last), (w == 8) ? 1 : 0);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
      checkVal($sformatf("%s out_valid after drain", tag), longint'(out_valid), 0);
      checkVal($sformatf("%s in_ready after drain", tag), longint'(in_ready), 1);
      checkVal($sformatf("%s busy after drain", tag), longint'(busy), 0);
   endtask

   task automatic checkIdle(input string tag);
      checkVal($sformatf("%s in_ready", tag), longint'(in_ready), 1);
      checkVal($sformatf("%s out_valid", tag), longint'(out_valid), 0);
      checkVal($sformatf("%s out_last", tag), longint'(out_last), 0);
      checkVal($sformatf("%s out_data", tag), longint'(out_data), 0);
      checkVal($sformatf("%s busy", tag), longint'(busy), 0);
   endtask

   initial begin
      mat_t ra, rb;

      tbl[0] = '{a: mk(1,2,3,4,5,6,7,8,9), b: mk(1,2,3,4,5,6,7,8,9),
                 y: mk(30,36,42,66,81,96,102,126,150), gap: 8'd0, stall: 8'd0, junk: 1'b0};
      tbl[1] = '{a: mk(-1,-2,-3,-4,-5,-6,-7,-8,-9), b: mk(-1,-2,-3,-4,-5,-6,-7,-8,-9),
                 y: mk(30,36,42,66,81,96,102,126,150), gap: 8'd0, stall: 8'd0, junk: 1'b1};
      tbl[2] = '{a: mk(1,-2,-3,-4,5,-6,-7,-8,9), b: mk(1,-2,-3,-4,5,-6,-7,-8,9),
                 y: mk(30,12,-18,18,81,-72,-38,-98,150), gap: 8'd0, stall: 8'd0, junk: 1'b0};
`ifdef SATURATE_EN
      tbl[3] = '{a: mk(300,0,0,0,0,0,0,0,0), b: mk(300,0,0,0,0,0,0,0,0),
                 y: mk(32767,0,0,0,0,0,0,0,0), gap: 8'd0, stall: 8'd0, junk: 1'b0};
`else
      tbl[3] = '{a: mk(300,0,0,0,0,0,0,0,0), b: mk(300,0,0,0,0,0,0,0,0),
                 y: mk(24464,0,0,0,0,0,0,0,0), gap: 8'd0, stall: 8'd0, junk: 1'b0};
`endif
      tbl[4] = '{a: mk(1,2,3,4,5,6,7,8,9), b: mk(1,2,3,4,5,6,7,8,9),
                 y: mk(30,36,42,66,81,96,102,126,150), gap: 8'd3, stall: 8'd5, junk: 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkIdle("reset");

      for (int t = 0; t < 5; t++) begin
         applyStimulus(tbl[t].a, tbl[t].b, int'(tbl[t].gap));
         waitResult(tbl[t].junk);
         checkOutput(tbl[t].y, int'(tbl[t].stall), $sformatf("vec%0d", t));
      end

      for (int r = 0; r < 6; r++) begin
         for (int n = 0; n < 9; n++) begin
            ra[n] = (r < 3) ? 16'($urandom) : 16'($urandom_range(200, 0) - 100);
            rb[n] = (r < 3) ? 16'($urandom) : 16'($urandom_range(200, 0) - 100);
         end
         applyStimulus(ra, rb, r % 3);
         waitResult(1'b0);
         checkOutput(refMul(ra, rb), r % 3, $sformatf("rand%0d", r));
      end

      // Reset after 7 operands, asserted together with a handshake that must be dropped.
      for (int n = 0; n < 7; n++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         @(negedge clk);
      end
      in_data = 16'h7fff;
      rst     = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      checkIdle("mid-load reset");
      applyStimulus(tbl[2].a, tbl[2].b, 0);
      waitResult(1'b0);
      checkOutput(tbl[2].y, 0, "after reset");

      // Reset while results are waiting in DRAIN discards them.
      applyStimulus(tbl[0].a, tbl[0].b, 0);
      waitResult(1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkIdle("drain reset");
      repeat (3) @(negedge clk);
      checkVal("drain reset stays idle", longint'(out_valid), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
